// File: rtl/l2t_sii_iq_rcv.sv
// ---------------------------------------------------------------------------
// l2t_sii_iq_rcv
//   L2-tag-side receiver for the SII->L2T request stream. Deserialises 32-bit
//   flits into a 64-bit header plus an optional 64-byte payload, and queues
//   each complete packet in an input queue (IQ) for the L2T pipe. IQ pops are
//   returned to SII as flow-control credits (iq_dequeue for every pop,
//   wib_dequeue additionally for WRI pops).
//
// Ports
//   iol2clk             : IO/L2 clock, all logic on posedge
//   rst                 : synchronous active-high reset
//   sii_l2t_req_vld     : 1-cycle packet-start strobe
//   sii_l2t_req[31:0]   : request flit bus (hdr hi, hdr lo, payload words)
//   pkt_rdy             : L2T pipe pops the IQ head
//   pkt_vld             : IQ non-empty
//   pkt_hdr[63:0]       : IQ head header
//   pkt_data[511:0]     : IQ head payload, word0 in [511:480]
//   pkt_has_data        : IQ head is WRI or WR8
//   l2t_sii_iq_dequeue  : 1-cycle pulse per IQ pop
//   l2t_sii_wib_dequeue : 1-cycle pulse per WRI pop
//   err[2:0]            : sticky [0] IQ overflow, [1] bad cmd,
//                         [2] vld during packet
// ---------------------------------------------------------------------------
module l2t_sii_iq_rcv #(
    parameter int unsigned IQ_DEPTH = 16,
    parameter int unsigned IQ_AW    = 4
) (
    input  logic         iol2clk,
    input  logic         rst,
    input  logic         sii_l2t_req_vld,
    input  logic [31:0]  sii_l2t_req,
    input  logic         pkt_rdy,
    output logic         pkt_vld,
    output logic [63:0]  pkt_hdr,
    output logic [511:0] pkt_data,
    output logic         pkt_has_data,
    output logic         l2t_sii_iq_dequeue,
    output logic         l2t_sii_wib_dequeue,
    output logic [2:0]   err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA
    } state_e;

    localparam logic [2:0] CMD_RD  = 3'b001;
    localparam logic [2:0] CMD_WRI = 3'b010;
    localparam logic [2:0] CMD_WR8 = 3'b100;

    // Deserialiser state
    state_e         state_q, state_d;
    logic [31:0]    hdr_hi_q, hdr_hi_d;
    logic [63:0]    hdr_q, hdr_d;
    logic [511:0]   data_q, data_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     last_q, last_d;
    logic           is_wri_q, is_wri_d;
    logic           has_data_q, has_data_d;
    logic [2:0]     err_q, err_d;
    logic [2:0]     cmd;
    logic           commit;

    // Input queue
    logic [63:0]    hdr_mem  [IQ_DEPTH];
    logic [511:0]   data_mem [IQ_DEPTH];
    logic           wri_mem  [IQ_DEPTH];
    logic           hasd_mem [IQ_DEPTH];
    logic [IQ_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IQ_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IQ_AW:0]   count_q, count_d;
    logic           iq_deq_q, iq_deq_d;
    logic           wib_deq_q, wib_deq_d;
    logic           full;
    logic           pop;
    logic           push;

    // cmd = header[61:59], which lives in the high header flit.
    assign cmd = hdr_hi_q[29:27];

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hdr_hi_q   <= '0;
            hdr_q      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            is_wri_q   <= 1'b0;
            has_data_q <= 1'b0;
            err_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            iq_deq_q   <= 1'b0;
            wib_deq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_hi_q   <= hdr_hi_d;
            hdr_q      <= hdr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            is_wri_q   <= is_wri_d;
            has_data_q <= has_data_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            iq_deq_q   <= iq_deq_d;
            wib_deq_q  <= wib_deq_d;
        end
    end

    // Next-state for the flit deserialiser. The commit cycle is the cycle of
    // the last flit; the entry is written at the end of it, so the packet is
    // visible one cycle later. A vld in the commit cycle is a legal start of
    // the next packet; any other vld while busy is flagged and ignored.
    always_comb begin
        state_d    = state_q;
        hdr_hi_d   = hdr_hi_q;
        hdr_d      = hdr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        is_wri_d   = is_wri_q;
        has_data_d = has_data_q;
        err_d      = err_q;
        commit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sii_l2t_req_vld) begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                hdr_hi_d = sii_l2t_req;
                data_d   = '0;
                if (sii_l2t_req_vld) begin
                    err_d[2] = 1'b1;
                end
                state_d = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                hdr_d      = {hdr_hi_q, sii_l2t_req};
                cnt_d      = '0;
                is_wri_d   = 1'b0;
                has_data_d = 1'b0;
                last_d     = '0;
                case (cmd)
                    CMD_RD: ;
                    CMD_WRI: begin
                        is_wri_d   = 1'b1;
                        has_data_d = 1'b1;
                        last_d     = 4'd15;
                    end
                    CMD_WR8: begin
                        has_data_d = 1'b1;
                        last_d     = 4'd1;
                    end
                    default: err_d[1] = 1'b1;
                endcase
                if (has_data_d) begin
                    state_d = ST_DATA;
                    if (sii_l2t_req_vld) begin
                        err_d[2] = 1'b1;
                    end
                end else begin
                    commit  = 1'b1;
                    state_d = sii_l2t_req_vld ? ST_HDR_HI : ST_IDLE;
                end
            end
            ST_DATA: begin
                for (int unsigned k = 0; k < 16; k++) begin
                    if (cnt_q == 4'(k)) begin
                        data_d[511 - 32*k -: 32] = sii_l2t_req;
                    end
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == last_q) begin
                    commit  = 1'b1;
                    state_d = sii_l2t_req_vld ? ST_HDR_HI : ST_IDLE;
                end else if (sii_l2t_req_vld) begin
                    err_d[2] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit && full && !pop) begin
            err_d[0] = 1'b1;
        end
    end

    // Queue control. A commit into a full queue still succeeds when the head
    // is popped in the same cycle, since the freed slot is the one written.
    assign full = (count_q == (IQ_AW+1)'(IQ_DEPTH));
    assign pop  = pkt_vld && pkt_rdy;
    assign push = commit && (!full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        iq_deq_d  = pop;
        wib_deq_d = pop && wri_mem[rd_ptr_q];
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge iol2clk) begin
        if (push && !rst) begin
            hdr_mem[wr_ptr_q]  <= hdr_d;
            data_mem[wr_ptr_q] <= data_d;
            wri_mem[wr_ptr_q]  <= is_wri_d;
            hasd_mem[wr_ptr_q] <= has_data_d;
        end
    end

    assign pkt_vld             = (count_q != '0);
    assign pkt_hdr             = pkt_vld ? hdr_mem[rd_ptr_q]  : '0;
    assign pkt_data            = pkt_vld ? data_mem[rd_ptr_q] : '0;
    assign pkt_has_data        = pkt_vld ? hasd_mem[rd_ptr_q] : 1'b0;
    assign l2t_sii_iq_dequeue  = iq_deq_q;
    assign l2t_sii_wib_dequeue = wib_deq_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_l2t_sii_iq_rcv.sv
// ---------------------------------------------------------------------------
// tb_l2t_sii_iq_rcv
//   Directed bench for l2t_sii_iq_rcv. Inputs are driven 1 ns after a rising
//   edge and outputs are observed at the same point, so every observation
//   reflects the state registered at the preceding edge.
// ---------------------------------------------------------------------------
module tb_l2t_sii_iq_rcv;

    logic         clk;
    logic         rst;
    logic         vld;
    logic [31:0]  req;
    logic         rdy;
    logic         pkt_vld;
    logic [63:0]  pkt_hdr;
    logic [511:0] pkt_data;
    logic         pkt_has_data;
    logic         iq_deq;
    logic         wib_deq;
    logic [2:0]   err;

    int checks = 0;
    int errors = 0;

    l2t_sii_iq_rcv #(.IQ_DEPTH(16), .IQ_AW(4)) dut (
        .iol2clk             (clk),
        .rst                 (rst),
        .sii_l2t_req_vld     (vld),
        .sii_l2t_req         (req),
        .pkt_rdy             (rdy),
        .pkt_vld             (pkt_vld),
        .pkt_hdr             (pkt_hdr),
        .pkt_data            (pkt_data),
        .pkt_has_data        (pkt_has_data),
        .l2t_sii_iq_dequeue  (iq_deq),
        .l2t_sii_wib_dequeue (wib_deq),
        .err                 (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        vld = v;
        req = d;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        req = '0;
        rdy = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Header-only packet; returns in cycle T+3.
    task automatic send_rd(input logic [63:0] h);
        drive(1'b1, 32'h0);
        drive(1'b0, h[63:32]);
        drive(1'b0, h[31:0]);
        req = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", pkt_vld); end
        checks++; if (pkt_hdr !== 64'h0) begin errors++; $display("FAIL reset_hdr: got %h expected 0", pkt_hdr); end
        checks++; if (pkt_data !== 512'h0) begin errors++; $display("FAIL reset_data: got nonzero expected 0"); end
        checks++; if (pkt_has_data !== 1'b0) begin errors++; $display("FAIL reset_has_data: got %b expected 0", pkt_has_data); end
        checks++; if ({iq_deq, wib_deq} !== 2'b00) begin errors++; $display("FAIL reset_deq: got %b expected 00", {iq_deq, wib_deq}); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", err); end
        // pkt_rdy on an empty queue produces no pulse.
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        checks++; if (iq_deq !== 1'b0) begin errors++; $display("FAIL empty_rdy_deq: got %b expected 0", iq_deq); end
    endtask

    task automatic test_rd();
        logic [63:0] h;
        h = 64'h0800_0000_0000_1040;
        do_reset();
        drive(1'b1, 32'h0);
        drive(1'b0, h[63:32]);
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL rd_vld_early: got %b expected 0", pkt_vld); end
        drive(1'b0, h[31:0]);
        req = '0;
        checks++; if (pkt_vld !== 1'b1) begin errors++; $display("FAIL rd_vld: got %b expected 1", pkt_vld); end
        checks++; if (pkt_hdr !== h) begin errors++; $display("FAIL rd_hdr: got %h expected %h", pkt_hdr, h); end
        checks++; if (pkt_has_data !== 1'b0) begin errors++; $display("FAIL rd_has_data: got %b expected 0", pkt_has_data); end
        checks++; if (pkt_data !== 512'h0) begin errors++; $display("FAIL rd_data: got nonzero expected 0"); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rd_err: got %b expected 000", err); end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        checks++; if ({iq_deq, wib_deq} !== 2'b10) begin errors++; $display("FAIL rd_pop_pulse: got %b expected 10", {iq_deq, wib_deq}); end
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL rd_pop_vld: got %b expected 0", pkt_vld); end
        step();
        checks++; if (iq_deq !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got %b expected 0", iq_deq); end
    endtask

    task automatic test_wri();
        logic [63:0]  h;
        logic [511:0] exp;
        h = 64'h1000_0000_0000_2000;
        exp = '0;
        for (int k = 0; k < 16; k++) exp[511 - 32*k -: 32] = 32'(k);
        do_reset();
        drive(1'b1, 32'h0);
        drive(1'b0, h[63:32]);
        drive(1'b0, h[31:0]);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL wri_vld_early: got %b expected 0", pkt_vld); end
            end
            drive(1'b0, 32'(k));
        end
        req = '0;
        checks++; if (pkt_vld !== 1'b1) begin errors++; $display("FAIL wri_vld: got %b expected 1", pkt_vld); end
        checks++; if (pkt_hdr !== h) begin errors++; $display("FAIL wri_hdr: got %h expected %h", pkt_hdr, h); end
        checks++; if (pkt_has_data !== 1'b1) begin errors++; $display("FAIL wri_has_data: got %b expected 1", pkt_has_data); end
        checks++; if (pkt_data[511:480] !== 32'h0) begin errors++; $display("FAIL wri_word0: got %h expected 0", pkt_data[511:480]); end
        checks++; if (pkt_data[31:0] !== 32'hF) begin errors++; $display("FAIL wri_word15: got %h expected f", pkt_data[31:0]); end
        checks++; if (pkt_data !== exp) begin errors++; $display("FAIL wri_data: got %h expected %h", pkt_data[255:0], exp[255:0]); end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        checks++; if ({iq_deq, wib_deq} !== 2'b11) begin errors++; $display("FAIL wri_pop_pulse: got %b expected 11", {iq_deq, wib_deq}); end
        step();
        checks++; if ({iq_deq, wib_deq} !== 2'b00) begin errors++; $display("FAIL wri_pulse_width: got %b expected 00", {iq_deq, wib_deq}); end
    endtask

    task automatic test_wr8();
        logic [63:0]  h;
        logic [511:0] exp;
        h = 64'h2000_0000_0000_3000;
        exp = {64'hAAAA_AAAA_5555_5555, 448'h0};
        do_reset();
        drive(1'b1, 32'h0);
        drive(1'b0, h[63:32]);
        drive(1'b0, h[31:0]);
        drive(1'b0, 32'hAAAA_AAAA);
        drive(1'b0, 32'h5555_5555);
        req = '0;
        checks++; if (pkt_vld !== 1'b1) begin errors++; $display("FAIL wr8_vld: got %b expected 1", pkt_vld); end
        checks++; if (pkt_has_data !== 1'b1) begin errors++; $display("FAIL wr8_has_data: got %b expected 1", pkt_has_data); end
        checks++; if (pkt_data !== exp) begin errors++; $display("FAIL wr8_data: got %h expected %h", pkt_data[511:448], exp[511:448]); end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        checks++; if ({iq_deq, wib_deq} !== 2'b10) begin errors++; $display("FAIL wr8_pop_pulse: got %b expected 10", {iq_deq, wib_deq}); end
    endtask

    task automatic test_bad_cmd();
        logic [63:0] h;
        h = 64'h2800_0000_0000_1040;   // cmd field 3'b101
        do_reset();
        send_rd(h);
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL badcmd_err: got %b expected 010", err); end
        checks++; if (pkt_vld !== 1'b1) begin errors++; $display("FAIL badcmd_vld: got %b expected 1", pkt_vld); end
        checks++; if (pkt_has_data !== 1'b0) begin errors++; $display("FAIL badcmd_has_data: got %b expected 0", pkt_has_data); end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        checks++; if ({iq_deq, wib_deq} !== 2'b10) begin errors++; $display("FAIL badcmd_pop_pulse: got %b expected 10", {iq_deq, wib_deq}); end
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL badcmd_err_sticky: got %b expected 010", err); end
    endtask

    task automatic test_overflow();
        logic [63:0] base;
        int pulses;
        base = 64'h0800_0000_0000_0000;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_rd(base | 64'(i));
            if (i == 15) begin
                checks++; if (err !== 3'b000) begin errors++; $display("FAIL ovf_err_at16: got %b expected 000", err); end
            end
        end
        checks++; if (err !== 3'b001) begin errors++; $display("FAIL ovf_err: got %b expected 001", err); end
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (pkt_hdr !== (base | 64'(i))) begin errors++; $display("FAIL ovf_head%0d: got %h expected %h", i, pkt_hdr, base | 64'(i)); end
            step();
            if (iq_deq === 1'b1) pulses++;
        end
        rdy = 1'b0;
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", pkt_vld); end
        checks++; if (pulses !== 16) begin errors++; $display("FAIL ovf_pulses: got %0d expected 16", pulses); end
        step();
        checks++; if (iq_deq !== 1'b0) begin errors++; $display("FAIL ovf_no_extra_pulse: got %b expected 0", iq_deq); end
    endtask

    task automatic test_full_pop();
        logic [63:0] base;
        logic [63:0] nh;
        logic [63:0] exp;
        base = 64'h0800_0000_0000_0100;
        nh   = 64'h0800_0000_0000_0FFF;
        do_reset();
        for (int i = 0; i < 16; i++) send_rd(base | 64'(i));
        drive(1'b1, 32'h0);
        drive(1'b0, nh[63:32]);
        rdy = 1'b1;
        drive(1'b0, nh[31:0]);
        rdy = 1'b0;
        req = '0;
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL fullpop_err: got %b expected 000", err); end
        checks++; if (iq_deq !== 1'b1) begin errors++; $display("FAIL fullpop_pulse: got %b expected 1", iq_deq); end
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? (base | 64'(i + 1)) : nh;
            checks++; if (pkt_hdr !== exp) begin errors++; $display("FAIL fullpop_head%0d: got %h expected %h", i, pkt_hdr, exp); end
            step();
        end
        rdy = 1'b0;
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b expected 0", pkt_vld); end
    endtask

    task automatic test_back_to_back();
        logic [63:0]  rh;
        logic [63:0]  wh;
        logic [511:0] exp;
        rh = 64'h0800_0000_0000_00B1;
        wh = 64'h1000_0000_0000_B2B0;
        exp = '0;
        for (int k = 0; k < 16; k++) exp[511 - 32*k -: 32] = 32'h100 + 32'(k);
        do_reset();
        drive(1'b1, 32'h0);
        drive(1'b0, rh[63:32]);
        drive(1'b1, rh[31:0]);      // commit cycle of RD and start of WRI
        checks++; if (pkt_hdr !== rh) begin errors++; $display("FAIL b2b_rd_hdr: got %h expected %h", pkt_hdr, rh); end
        drive(1'b0, wh[63:32]);
        drive(1'b0, wh[31:0]);
        for (int k = 0; k < 16; k++) drive(k == 2, 32'h100 + 32'(k));
        vld = 1'b0;
        req = '0;
        checks++; if (err !== 3'b100) begin errors++; $display("FAIL b2b_err: got %b expected 100", err); end
        checks++; if (pkt_hdr !== rh) begin errors++; $display("FAIL b2b_head_rd: got %h expected %h", pkt_hdr, rh); end
        rdy = 1'b1;
        step();
        checks++; if ({iq_deq, wib_deq} !== 2'b10) begin errors++; $display("FAIL b2b_pop1: got %b expected 10", {iq_deq, wib_deq}); end
        checks++; if (pkt_hdr !== wh) begin errors++; $display("FAIL b2b_head_wri: got %h expected %h", pkt_hdr, wh); end
        checks++; if (pkt_data !== exp) begin errors++; $display("FAIL b2b_wri_data: got %h expected %h", pkt_data[255:0], exp[255:0]); end
        step();
        rdy = 1'b0;
        checks++; if ({iq_deq, wib_deq} !== 2'b11) begin errors++; $display("FAIL b2b_pop2: got %b expected 11", {iq_deq, wib_deq}); end
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", pkt_vld); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] wh;
        logic [63:0] nh;
        wh = 64'h1000_0000_0000_D000;
        nh = 64'h0800_0000_0000_00C5;
        do_reset();
        send_rd(64'h0800_0000_0000_0001);
        drive(1'b1, 32'h0);
        drive(1'b1, wh[63:32]);     // stray vld sets err[2]
        drive(1'b0, wh[31:0]);
        for (int k = 0; k < 7; k++) drive(1'b0, 32'(k));
        checks++; if (err !== 3'b100) begin errors++; $display("FAIL rstmid_pre_err: got %b expected 100", err); end
        rst = 1'b1;
        rdy = 1'b1;
        drive(1'b0, 32'h7);
        rst = 1'b0;
        rdy = 1'b0;
        req = '0;
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld: got %b expected 0", pkt_vld); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rstmid_err: got %b expected 000", err); end
        checks++; if ({iq_deq, wib_deq} !== 2'b00) begin errors++; $display("FAIL rstmid_deq: got %b expected 00", {iq_deq, wib_deq}); end
        step();
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL rstmid_no_commit: got %b expected 0", pkt_vld); end
        send_rd(nh);
        checks++; if (pkt_vld !== 1'b1) begin errors++; $display("FAIL rstmid_next_vld: got %b expected 1", pkt_vld); end
        checks++; if (pkt_hdr !== nh) begin errors++; $display("FAIL rstmid_next_hdr: got %h expected %h", pkt_hdr, nh); end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        checks++; if ({iq_deq, wib_deq} !== 2'b10) begin errors++; $display("FAIL rstmid_pop: got %b expected 10", {iq_deq, wib_deq}); end
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %b expected 0", pkt_vld); end
    endtask

    initial begin
        rst = 1'b1;
        vld = 1'b0;
        req = '0;
        rdy = 1'b0;
        test_reset();
        test_rd();
        test_wri();
        test_wr8();
        test_bad_cmd();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
